prio_encoder_rr: RTL

//  Parametrised, registered priority encoder with valid/ready handshakes on both sides.

---
 rtl/prio_encoder_rr.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/prio_encoder_rr.sv
// Purpose: registered N-bit priority encoder (fixed or round-robin) with valid/ready on both sides.
// Latency: 1 cycle from input transfer to out_valid; back-to-back transfers with no bubble.
// Backpressure: in_ready = ~out_valid | out_ready; while held FULL all outputs are frozen.
//
// Ports:
//   clk, rst_n                  rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready         input handshake; in_req is encoded on an input transfer
//   in_req[N-1:0]               request vector, bit i = request i
//   out_valid / out_ready       output handshake on the single result register
//   out_idx[W-1:0]              index of the winning request (0 when no hit)
//   out_onehot[N-1:0]           one-hot of the winner (0 when no hit)
//   out_hit                     any request bit was set
//
// RR=0: lowest set index wins. RR=1: the search begins at a rotating pointer
// and wraps at N (not at 2^W), so non-power-of-two N is handled correctly.

module prio_encoder_rr #(
   parameter  int N  = 8,
   parameter  int RR = 0,
   localparam int W  = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_req,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] out_onehot,
   output logic         out_hit
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t       state_q, state_d;
   logic [W-1:0] idx_q, idx_d;
   logic [N-1:0] onehot_q, onehot_d;
   logic         hit_q, hit_d;
   logic [W-1:0] ptr_q, ptr_d;

   logic         in_xfer;
   logic [N-1:0] search_mask;
   logic [N-1:0] masked_req;
   logic [N-1:0] sel_req;
   logic [N-1:0] win_onehot;
   logic [W-1:0] win_idx;
   logic         win_hit;

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   assign out_valid = (state_q == ST_FULL);
   assign in_ready  = ~out_valid | out_ready;
   assign in_xfer   = in_valid & in_ready;

   // ------------------------------------------------------------------
   // Encoder
   // The round-robin search is done as two fixed-priority searches: first
   // over the requests at or above ptr, and if none are set, over the whole
   // vector (which then finds the lowest index below ptr). In fixed mode
   // ptr stays at 0, so the first search already covers every bit.
   // ------------------------------------------------------------------
   always_comb begin
      search_mask = '0;
      for (int i = 0; i < N; i++) begin
         search_mask[i] = (W'(i) >= ptr_q);
      end

      masked_req = in_req & search_mask;
      sel_req    = (|masked_req) ? masked_req : in_req;

      // Isolate the lowest set bit: x & -x.
      win_onehot = sel_req & (~sel_req + N'(1));
      win_hit    = |in_req;

      // The winner vector is one-hot (or zero), so OR-ing indices is exact.
      win_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (win_onehot[i]) begin
            win_idx = win_idx | W'(i);
         end
      end
   end

   // ------------------------------------------------------------------
   // Next state, result register and pointer
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      onehot_d = onehot_q;
      hit_d    = hit_q;
      ptr_d    = ptr_q;

      case (state_q)
         ST_EMPTY: begin
            if (in_xfer) begin
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            // A new input transfer while FULL implies out_ready=1, so the
            // held result leaves and the new one replaces it in one edge.
            if (in_xfer) begin
               state_d = ST_FULL;
            end else if (out_ready) begin
               state_d = ST_EMPTY;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase

      if (in_xfer) begin
         idx_d    = win_idx;
         onehot_d = win_onehot;
         hit_d    = win_hit;
      end

      // Pointer advances past the winner; no-hit transfers leave it alone.
      if ((RR != 0) && in_xfer && win_hit) begin
         if (win_idx == W'(N - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = win_idx + W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_EMPTY;
         idx_q    <= '0;
         onehot_q <= '0;
         hit_q    <= 1'b0;
         ptr_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         onehot_q <= onehot_d;
         hit_q    <= hit_d;
         ptr_q    <= ptr_d;
      end
   end

   assign out_idx    = idx_q;
   assign out_onehot = onehot_q;
   assign out_hit    = hit_q;

endmodule
